// File: rtl/fp16div.sv
// Sequential FP16 divider (restoring radix-2), fixed 14-cycle start-to-done latency.
// Define FP16DIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp16div (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] x
);

`ifdef FP16DIV_RNE_EN
   localparam logic RNE = 1'b1;
`else
   localparam logic RNE = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRE,
      S_DIV,
      S_RND
   } state_t;

   typedef enum logic [1:0] {
      SP_NONE,
      SP_INF,
      SP_ZERO
   } spec_t;

   state_t             r_state;
   state_t             w_next;
   spec_t              r_spec;
   spec_t              w_spec;

   logic [15:0]        r_a;
   logic [15:0]        r_b;
   logic               r_sign;
   logic signed [6:0]  r_exp;
   logic [12:0]        r_rem;
   logic [10:0]        r_mb;
   logic [10:0]        r_q;
   logic [3:0]         r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [15:0]        r_x;

   logic [4:0]         w_ea;
   logic [4:0]         w_eb;
   logic [10:0]        w_ma;
   logic [10:0]        w_mb;
   logic               w_lt;
   logic [6:0]         w_e0;
   logic [12:0]        w_div0;

   logic               w_ge;
   logic [11:0]        w_sub;
   logic [12:0]        w_rem_n;

   logic               w_guard;
   logic               w_sticky;
   logic               w_lsb;
   logic               w_up;
   logic [10:0]        w_mant_r;
   logic               w_carry;
   logic [9:0]         w_frac_r;
   logic signed [6:0]  w_exp_r;
   logic [15:0]        w_res;

   // Operand classification and mantissa alignment (PRE)
   assign w_ea   = r_a[14:10];
   assign w_eb   = r_b[14:10];
   assign w_ma   = {1'b1, r_a[9:0]};
   assign w_mb   = {1'b1, r_b[9:0]};
   assign w_lt   = (w_ma < w_mb);
   assign w_e0   = {2'b00, w_ea} - {2'b00, w_eb} + 7'd15 - {6'd0, w_lt};
   assign w_div0 = w_lt ? {1'b0, w_ma, 1'b0} : {2'b00, w_ma};

   always_comb begin
      w_spec = SP_NONE;
      if ((w_ea == 5'h1F) || (w_eb == 5'h1F)) begin
         w_spec = SP_INF;
      end else if (w_eb == 5'h00) begin
         w_spec = SP_INF;
      end else if (w_ea == 5'h00) begin
         w_spec = SP_ZERO;
      end
   end

   // One restoring step; remainder stays below 2*mb so 13 bits suffice
   assign w_ge    = (r_rem >= {2'b00, r_mb});
   assign w_sub   = 12'(r_rem - {2'b00, r_mb});
   assign w_rem_n = w_ge ? {w_sub, 1'b0} : {r_rem[11:0], 1'b0};

   // Rounding and packing (RND)
   assign w_guard  = r_q[0];
   assign w_sticky = |r_rem;
   assign w_lsb    = r_q[1];
   assign w_up     = RNE & w_guard & (w_sticky | w_lsb);
   assign w_mant_r = {1'b0, r_q[10:1]} + {10'd0, w_up};
   assign w_carry  = w_mant_r[10];
   assign w_frac_r = w_carry ? 10'd0 : w_mant_r[9:0];
   assign w_exp_r  = r_exp + $signed({6'd0, w_carry});

   always_comb begin
      w_res = {r_sign, w_exp_r[4:0], w_frac_r};
      if (r_spec == SP_INF) begin
         w_res = {r_sign, 5'h1F, 10'd0};
      end else if (r_spec == SP_ZERO) begin
         w_res = {r_sign, 15'd0};
      end else if (w_exp_r >= 7'sd31) begin
         w_res = {r_sign, 5'h1F, 10'd0};
      end else if (w_exp_r <= 7'sd0) begin
         w_res = {r_sign, 15'd0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (start) w_next = S_PRE;
         S_PRE:  w_next = S_DIV;
         S_DIV:  if (r_cnt == 4'd11) w_next = S_RND;
         S_RND:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= 16'd0;
         r_b    <= 16'd0;
         r_sign <= 1'b0;
         r_exp  <= 7'sd0;
         r_rem  <= 13'd0;
         r_mb   <= 11'd0;
         r_q    <= 11'd0;
         r_cnt  <= 4'd0;
         r_spec <= SP_NONE;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_x    <= 16'd0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a    <= a;
                  r_b    <= b;
                  r_busy <= 1'b1;
               end
            end
            S_PRE: begin
               r_sign <= r_a[15] ^ r_b[15];
               r_exp  <= $signed(w_e0);
               r_rem  <= w_div0;
               r_mb   <= w_mb;
               r_q    <= 11'd0;
               r_cnt  <= 4'd0;
               r_spec <= w_spec;
            end
            S_DIV: begin
               r_rem <= w_rem_n;
               r_q   <= {r_q[9:0], w_ge};
               r_cnt <= r_cnt + 4'd1;
            end
            S_RND: begin
               r_x    <= w_res;
               r_done <= 1'b1;
               r_busy <= 1'b0;
               r_cnt  <= 4'd0;
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign x    = r_x;

endmodule
